tx_data_gen: RTL

// - Parametrised successor packet-data source for the PSK transmitter; feeds the Packetizer over AXI-Stream.
// - Generates PN payload in BPSK, QPSK or alternating-MIX packets with run-time payload length and a fully AXIS-compliant tready handshake.
// - Adds inter-packet gap control and per-packet statistics.

---
 rtl/tx_data_gen.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/tx_data_gen.sv
`default_nettype none
// ============================================================================
// Module   : tx_data_gen
// Brief    : PN payload packet source (BPSK/QPSK/MIX) on AXI-Stream, with
//            inter-packet gap and packet counter. Optional TX_DATA_GEN_SEQ_HDR_EN
//            prefixes each packet with a sequence-number header beat.
// Revision : 1.0 - initial release
// ============================================================================
module tx_data_gen #(
  parameter int BYTES = 1,
  parameter int LEN_W = 16,
  parameter int GAP_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           MODE_CTRL,
  input  logic [LEN_W-1:0]     payload_length,
  input  logic [GAP_W-1:0]     gap_cycles,
  input  logic                 enable,
  input  logic                 pkt_sent,
  output logic [8*BYTES-1:0]   data_tdata,
  output logic                 data_tvalid,
  input  logic                 data_tready,
  output logic                 data_tlast,
  output logic                 data_tuser,
  output logic [15:0]          pkt_cnt,
  output logic                 busy
);

  localparam int BITS = 8 * BYTES;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [4:0]        pn5_q, pn5_d;
  logic [3:0]        pn4_q, pn4_d;
  logic              bpsk_q, bpsk_d;
  logic              mix_q, mix_d;
  logic              mix_is_bpsk_q, mix_is_bpsk_d;
  logic [15:0]       pkt_cnt_q, pkt_cnt_d;
  logic [BITS-1:0]   tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;
  logic              tuser_q, tuser_d;
`ifdef TX_DATA_GEN_SEQ_HDR_EN
  logic              hdr_q, hdr_d;
`endif

  logic              w_accept;
  logic              w_mode_bpsk;
  logic              w_mode_mix;
  logic [4:0]        w_pn5_nx;
  logic [3:0]        w_pn4_nx;

  function automatic logic [BITS-1:0] beat(input logic b5, input logic b4, input logic bpsk);
    beat = bpsk ? {BITS{b5}} : {{(BITS-1){b5}}, b4};
  endfunction

  // Fibonacci form, output taken from bit 0, new bit enters at the top.
  assign w_pn5_nx = {pn5_q[0] ^ pn5_q[3], pn5_q[4:1]};
  assign w_pn4_nx = {pn4_q[0] ^ pn4_q[3], pn4_q[3:1]};

  assign w_accept    = tvalid_q && data_tready;
  assign w_mode_mix  = (MODE_CTRL != 4'b0001) && (MODE_CTRL != 4'b0010);
  assign w_mode_bpsk = (MODE_CTRL == 4'b0001) ? 1'b1 :
                       (MODE_CTRL == 4'b0010) ? 1'b0 : mix_is_bpsk_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      len_q         <= '0;
      cnt_q         <= '0;
      gap_q         <= '0;
      pn5_q         <= 5'b00001;
      pn4_q         <= 4'b0001;
      bpsk_q        <= 1'b0;
      mix_q         <= 1'b0;
      mix_is_bpsk_q <= 1'b1;
      pkt_cnt_q     <= '0;
      tdata_q       <= '0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      tuser_q       <= 1'b0;
`ifdef TX_DATA_GEN_SEQ_HDR_EN
      hdr_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      gap_q         <= gap_d;
      pn5_q         <= pn5_d;
      pn4_q         <= pn4_d;
      bpsk_q        <= bpsk_d;
      mix_q         <= mix_d;
      mix_is_bpsk_q <= mix_is_bpsk_d;
      pkt_cnt_q     <= pkt_cnt_d;
      tdata_q       <= tdata_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
      tuser_q       <= tuser_d;
`ifdef TX_DATA_GEN_SEQ_HDR_EN
      hdr_q         <= hdr_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    gap_d         = gap_q;
    pn5_d         = pn5_q;
    pn4_d         = pn4_q;
    bpsk_d        = bpsk_q;
    mix_d         = mix_q;
    mix_is_bpsk_d = mix_is_bpsk_q;
    pkt_cnt_d     = pkt_cnt_q;
    tdata_d       = tdata_q;
    tvalid_d      = tvalid_q;
    tlast_d       = tlast_q;
    tuser_d       = tuser_q;
`ifdef TX_DATA_GEN_SEQ_HDR_EN
    hdr_d         = hdr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (enable && (payload_length != '0)) begin
          state_d  = S_SEND;
          len_d    = payload_length;
          cnt_d    = '0;
          bpsk_d   = w_mode_bpsk;
          mix_d    = w_mode_mix;
          tvalid_d = 1'b1;
          tuser_d  = w_mode_bpsk;
`ifdef TX_DATA_GEN_SEQ_HDR_EN
          hdr_d    = 1'b1;
          tdata_d  = BITS'(pkt_cnt_q);
          tlast_d  = 1'b0;
`else
          tdata_d  = beat(pn5_q[0], pn4_q[0], w_mode_bpsk);
          tlast_d  = (payload_length == LEN_W'(1));
`endif
        end
      end

      S_SEND: begin
        if (w_accept) begin
`ifdef TX_DATA_GEN_SEQ_HDR_EN
          // Header beat does not consume PN bits; first payload beat follows.
          if (hdr_q) begin
            hdr_d   = 1'b0;
            tdata_d = beat(pn5_q[0], pn4_q[0], bpsk_q);
            tlast_d = (len_q == LEN_W'(1));
          end else
`endif
          begin
            pn5_d = w_pn5_nx;
            pn4_d = w_pn4_nx;
            if (tlast_q) begin
              state_d   = S_WAIT;
              tvalid_d  = 1'b0;
              tlast_d   = 1'b0;
              tuser_d   = 1'b0;
              tdata_d   = '0;
              pkt_cnt_d = pkt_cnt_q + 16'd1;
            end else begin
              cnt_d   = cnt_q + LEN_W'(1);
              tdata_d = beat(w_pn5_nx[0], w_pn4_nx[0], bpsk_q);
              tlast_d = ((cnt_q + LEN_W'(1)) == (len_q - LEN_W'(1)));
            end
          end
        end
      end

      S_WAIT: begin
        if (pkt_sent) begin
          if (mix_q) begin
            mix_is_bpsk_d = ~mix_is_bpsk_q;
          end
          if (gap_cycles == '0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_GAP;
            gap_d   = gap_cycles;
          end
        end
      end

      S_GAP: begin
        gap_d = gap_q - GAP_W'(1);
        if (gap_q == GAP_W'(1)) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign data_tdata  = tdata_q;
  assign data_tvalid = tvalid_q;
  assign data_tlast  = tlast_q;
  assign data_tuser  = tuser_q;
  assign pkt_cnt     = pkt_cnt_q;
  assign busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire
